gpr_regfile: RTL and testbench
==============================

Name: gpr_regfile

Overview:
- 32-entry x 64-bit general-purpose register file for the dual-issue PowerPC pipeline core.
- Two independent read ports feed the decode/execute operand path; two independent write ports serve the two write-back lanes (lane 0 = older instruction, lane 1 = younger).
- Synchronous reads and writes on one clock; asynchronous active-low reset clears all state.

Parameters:
- NREGS, 32, number of registers; must equal 2^AW.
- AW, 5, register address width.
- DW, 64, data width; bit 0 is the MSB (big-endian [0:DW-1] numbering, matching the core).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ren0  in  1  read port 0 enable.
- raddr0  in  AW  read port 0 register index.
- rdata0  out  DW  read port 0 data, registered.
- ren1  in  1  read port 1 enable.
- raddr1  in  AW  read port 1 register index.
- rdata1  out  DW  read port 1 data, registered.
- wen0  in  1  write port 0 enable (lane 0).
- waddr0  in  AW  write port 0 register index.
- wdata0  in  DW  write port 0 data.
- wen1  in  1  write port 1 enable (lane 1).
- waddr1  in  AW  write port 1 register index.
- wdata1  in  DW  write port 1 data.

Behaviour:
- Reset (rst_n low, asynchronous, independent of clk):
  - all NREGS registers = 0; rdata0 = rdata1 = 0.
  - reads and writes are ignored while rst_n is low.
  - deasserting rst_n mid-operation takes effect at the next rising edge; no partial write survives a reset.
- Register 0 is an ordinary storage register, not hardwired to zero; r0-as-zero decoding belongs to the pipeline.
- Writes:
  - on a rising edge with wenN=1, reg[waddrN] <= wdataN.
  - both ports enabled with different addresses: both writes commit in the same cycle.
  - both ports enabled with the same address: port 1 (younger lane) wins; port 0 data is discarded.
- Reads:
  - 1-cycle latency: on a rising edge with renN=1, rdataN <= value of reg[raddrN].
  - with renN=0, rdataN holds its previous value.
  - both read ports may address the same register in the same cycle.
- Read/write same cycle, same address (write-through bypass):
  - rdataN captures the value being written that edge, not the old contents.
  - priority for the captured value: wdata1 if wen1 and waddr1 matches; else wdata0 if wen0 and waddr0 matches; else stored contents.
- No undefined X propagation: every output is driven from a reset flop.
- No stalls or handshake: the block accepts any combination of enables every cycle.

Test Plan:
1. Reset, then ren0=ren1=1 at addresses 0 and 31 -> rdata0 = rdata1 = 0 one cycle later. Assert rst_n low mid-stream after writes -> outputs go to 0 immediately; all registers read back 0.
2. Write 0x0123456789ABCDEF to r5 via port 0, then 0xFFFFFFFFFFFFFFFF to r0 via port 1 the next cycle, then read r5 on port 0 and r0 on port 1 -> both written values appear exactly 1 cycle after the read edge (r0 is not zero-forced).
3. Same cycle: wen0 r7 = 0xAAAA, wen1 r7 = 0x5555; then read r7 -> 0x5555. Same cycle: wen0 r8 = 1, wen1 r9 = 2 -> r8 = 1 and r9 = 2.
4. Bypass: r3 holds 0x10; in the same cycle write r3 = 0x20 on port 0 and read r3 on both ports -> rdata0 = rdata1 = 0x20 after that edge. Repeat with both write ports targeting r3 (0x30 on port 0, 0x40 on port 1) -> 0x40.
5. Hold: read r5 with ren0=1, then ren0=0 while r5 is rewritten to 0x99 -> rdata0 keeps the old value until ren0 is reasserted, then shows 0x99.
6. Random regression: 10k cycles of random enables, addresses and data against a reference model using the priority and bypass rules above -> zero mismatches.

Source files
------------

// File: rtl/gpr_regfile.sv
// gpr_regfile: 32 x 64-bit general-purpose register file, two registered
// read ports and two write ports. Lane 1 (younger) wins same-address write
// collisions. Reads see same-edge writes through a bypass.
// Data uses big-endian [0:DW-1] bit numbering to match the core.
module gpr_regfile #(
  parameter int unsigned NREGS = 32,
  parameter int unsigned AW    = 5,
  parameter int unsigned DW    = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ren0,
  input  logic [AW-1:0] raddr0,
  output logic [0:DW-1] rdata0,
  input  logic          ren1,
  input  logic [AW-1:0] raddr1,
  output logic [0:DW-1] rdata1,
  input  logic          wen0,
  input  logic [AW-1:0] waddr0,
  input  logic [0:DW-1] wdata0,
  input  logic          wen1,
  input  logic [AW-1:0] waddr1,
  input  logic [0:DW-1] wdata1
);

  logic [0:DW-1] mem_q [NREGS];
  logic [0:DW-1] mem_d [NREGS];
  logic [0:DW-1] rdata0_q, rdata0_d;
  logic [0:DW-1] rdata1_q, rdata1_d;

  // Next storage contents: lane 0 applied first so lane 1 overrides on collision
  always_comb begin
    mem_d = mem_q;
    if (wen0) mem_d[waddr0] = wdata0;
    if (wen1) mem_d[waddr1] = wdata1;
  end

  // Read capture with write-through bypass; a disabled port holds its value
  always_comb begin
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    if (ren0) begin
      if (wen1 && (waddr1 == raddr0))      rdata0_d = wdata1;
      else if (wen0 && (waddr0 == raddr0)) rdata0_d = wdata0;
      else                                 rdata0_d = mem_q[raddr0];
    end
    if (ren1) begin
      if (wen1 && (waddr1 == raddr1))      rdata1_d = wdata1;
      else if (wen0 && (waddr0 == raddr1)) rdata1_d = wdata0;
      else                                 rdata1_d = mem_q[raddr1];
    end
  end

  // Storage and read-data registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) mem_q[i] <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      mem_q    <= mem_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign rdata0 = rdata0_q;
  assign rdata1 = rdata1_q;

endmodule

// File: tb/tb_gpr_regfile.sv
// Directed and randomized checks for gpr_regfile.
module tb_gpr_regfile;

  logic        clk;
  logic        rst_n;
  logic        ren0, ren1, wen0, wen1;
  logic [4:0]  raddr0, raddr1, waddr0, waddr1;
  logic [0:63] wdata0, wdata1;
  logic [0:63] rdata0, rdata1;

  int unsigned tests_run;
  int unsigned fails;

  gpr_regfile #(.NREGS(32), .AW(5), .DW(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .ren0(ren0), .raddr0(raddr0), .rdata0(rdata0),
    .ren1(ren1), .raddr1(raddr1), .rdata1(rdata1),
    .wen0(wen0), .waddr0(waddr0), .wdata0(wdata0),
    .wen1(wen1), .waddr1(waddr1), .wdata1(wdata1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ren0 = 0; ren1 = 0; wen0 = 0; wen1 = 0;
    raddr0 = '0; raddr1 = '0; waddr0 = '0; waddr1 = '0;
    wdata0 = '0; wdata1 = '0;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if (rdata0 !== 64'h0) begin fails++; $display("FAIL reset_rdata0: got %h expected %h", rdata0, 64'h0); end
    tests_run++;
    if (rdata1 !== 64'h0) begin fails++; $display("FAIL reset_rdata1: got %h expected %h", rdata1, 64'h0); end
    step();
    rst_n = 1'b1;
    ren0 = 1; raddr0 = 5'd0; ren1 = 1; raddr1 = 5'd31;
    step();
    tests_run++;
    if (rdata0 !== 64'h0) begin fails++; $display("FAIL reset_r0: got %h expected %h", rdata0, 64'h0); end
    tests_run++;
    if (rdata1 !== 64'h0) begin fails++; $display("FAIL reset_r31: got %h expected %h", rdata1, 64'h0); end
    idle();
  endtask

  task automatic test_write_read();
    idle();
    wen0 = 1; waddr0 = 5'd5; wdata0 = 64'h0123456789ABCDEF;
    step();
    idle();
    wen1 = 1; waddr1 = 5'd0; wdata1 = 64'hFFFFFFFFFFFFFFFF;
    step();
    idle();
    ren0 = 1; raddr0 = 5'd5; ren1 = 1; raddr1 = 5'd0;
    step();
    tests_run++;
    if (rdata0 !== 64'h0123456789ABCDEF) begin fails++; $display("FAIL wr_r5: got %h expected %h", rdata0, 64'h0123456789ABCDEF); end
    tests_run++;
    if (rdata1 !== 64'hFFFFFFFFFFFFFFFF) begin fails++; $display("FAIL wr_r0: got %h expected %h", rdata1, 64'hFFFFFFFFFFFFFFFF); end
    idle();
  endtask

  task automatic test_dual_write();
    idle();
    wen0 = 1; waddr0 = 5'd7; wdata0 = 64'hAAAA;
    wen1 = 1; waddr1 = 5'd7; wdata1 = 64'h5555;
    step();
    idle();
    ren0 = 1; raddr0 = 5'd7;
    step();
    tests_run++;
    if (rdata0 !== 64'h5555) begin fails++; $display("FAIL collide_r7: got %h expected %h", rdata0, 64'h5555); end
    idle();
    wen0 = 1; waddr0 = 5'd8; wdata0 = 64'h1;
    wen1 = 1; waddr1 = 5'd9; wdata1 = 64'h2;
    step();
    idle();
    ren0 = 1; raddr0 = 5'd8; ren1 = 1; raddr1 = 5'd9;
    step();
    tests_run++;
    if (rdata0 !== 64'h1) begin fails++; $display("FAIL dual_r8: got %h expected %h", rdata0, 64'h1); end
    tests_run++;
    if (rdata1 !== 64'h2) begin fails++; $display("FAIL dual_r9: got %h expected %h", rdata1, 64'h2); end
    idle();
  endtask

  task automatic test_bypass();
    idle();
    wen0 = 1; waddr0 = 5'd3; wdata0 = 64'h10;
    step();
    idle();
    wen0 = 1; waddr0 = 5'd3; wdata0 = 64'h20;
    ren0 = 1; raddr0 = 5'd3; ren1 = 1; raddr1 = 5'd3;
    step();
    tests_run++;
    if (rdata0 !== 64'h20) begin fails++; $display("FAIL bypass_p0_rd0: got %h expected %h", rdata0, 64'h20); end
    tests_run++;
    if (rdata1 !== 64'h20) begin fails++; $display("FAIL bypass_p0_rd1: got %h expected %h", rdata1, 64'h20); end
    wen0 = 1; waddr0 = 5'd3; wdata0 = 64'h30;
    wen1 = 1; waddr1 = 5'd3; wdata1 = 64'h40;
    step();
    tests_run++;
    if (rdata0 !== 64'h40) begin fails++; $display("FAIL bypass_p1_rd0: got %h expected %h", rdata0, 64'h40); end
    tests_run++;
    if (rdata1 !== 64'h40) begin fails++; $display("FAIL bypass_p1_rd1: got %h expected %h", rdata1, 64'h40); end
    idle();
    ren0 = 1; raddr0 = 5'd3;
    step();
    tests_run++;
    if (rdata0 !== 64'h40) begin fails++; $display("FAIL bypass_stored: got %h expected %h", rdata0, 64'h40); end
    idle();
  endtask

  task automatic test_hold();
    idle();
    ren0 = 1; raddr0 = 5'd5;
    step();
    ren0 = 0;
    wen0 = 1; waddr0 = 5'd5; wdata0 = 64'h99;
    step();
    tests_run++;
    if (rdata0 !== 64'h0123456789ABCDEF) begin fails++; $display("FAIL hold_1: got %h expected %h", rdata0, 64'h0123456789ABCDEF); end
    idle();
    step();
    tests_run++;
    if (rdata0 !== 64'h0123456789ABCDEF) begin fails++; $display("FAIL hold_2: got %h expected %h", rdata0, 64'h0123456789ABCDEF); end
    ren0 = 1; raddr0 = 5'd5;
    step();
    tests_run++;
    if (rdata0 !== 64'h99) begin fails++; $display("FAIL hold_reread: got %h expected %h", rdata0, 64'h99); end
    idle();
  endtask

  task automatic test_reset_mid();
    idle();
    wen0 = 1; waddr0 = 5'd12; wdata0 = 64'hDEADBEEFCAFEF00D;
    wen1 = 1; waddr1 = 5'd13; wdata1 = 64'h1122334455667788;
    step();
    idle();
    ren0 = 1; raddr0 = 5'd12; ren1 = 1; raddr1 = 5'd13;
    step();
    tests_run++;
    if (rdata0 !== 64'hDEADBEEFCAFEF00D) begin fails++; $display("FAIL prereset_r12: got %h expected %h", rdata0, 64'hDEADBEEFCAFEF00D); end
    // assert reset between edges with a write pending
    wen0 = 1; waddr0 = 5'd14; wdata0 = 64'h77;
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if (rdata0 !== 64'h0) begin fails++; $display("FAIL midreset_rd0: got %h expected %h", rdata0, 64'h0); end
    tests_run++;
    if (rdata1 !== 64'h0) begin fails++; $display("FAIL midreset_rd1: got %h expected %h", rdata1, 64'h0); end
    step();
    step();
    #2 rst_n = 1'b1;
    idle();
    for (int i = 0; i < 32; i++) begin
      ren0 = 1; raddr0 = 5'(i);
      ren1 = 1; raddr1 = 5'(31 - i);
      step();
      tests_run++;
      if (rdata0 !== 64'h0) begin fails++; $display("FAIL postreset_rd0 r%0d: got %h expected %h", i, rdata0, 64'h0); end
      tests_run++;
      if (rdata1 !== 64'h0) begin fails++; $display("FAIL postreset_rd1 r%0d: got %h expected %h", 31 - i, rdata1, 64'h0); end
    end
    idle();
  endtask

  task automatic test_random();
    logic [0:63] model [32];
    logic [0:63] exp0, exp1;
    idle();
    #2 rst_n = 1'b0;
    #3 rst_n = 1'b1;
    for (int i = 0; i < 32; i++) model[i] = '0;
    exp0 = '0;
    exp1 = '0;
    for (int c = 0; c < 10000; c++) begin
      ren0 = 1'($urandom); ren1 = 1'($urandom);
      wen0 = 1'($urandom); wen1 = 1'($urandom);
      raddr0 = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      raddr1 = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      waddr0 = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      waddr1 = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      wdata0 = {$urandom, $urandom};
      wdata1 = {$urandom, $urandom};
      if (wen0) model[waddr0] = wdata0;
      if (wen1) model[waddr1] = wdata1;
      if (ren0) exp0 = model[raddr0];
      if (ren1) exp1 = model[raddr1];
      step();
      tests_run++;
      if (rdata0 !== exp0) begin fails++; $display("FAIL rand_rd0 cyc%0d: got %h expected %h", c, rdata0, exp0); end
      tests_run++;
      if (rdata1 !== exp1) begin fails++; $display("FAIL rand_rd1 cyc%0d: got %h expected %h", c, rdata1, exp1); end
    end
    idle();
  endtask

  initial begin
    tests_run = 0;
    fails = 0;
    test_reset();
    test_write_read();
    test_dual_write();
    test_bypass();
    test_hold();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
